div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 102 ++++++++++
 tb/tb_div_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle 32-bit signed/unsigned restoring divider with {remainder, quotient} result
module div_ctrl (
   input  logic        clk,
   input  logic        Rst_n,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        stall_req_o
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [64:0] dividend;
   logic [31:0] divisor;
   logic        neg_quot;
   logic        neg_rem;

   logic [31:0] abs1;
   logic [31:0] abs2;
   logic [64:0] shifted;
   logic [33:0] trial;
   logic [31:0] quot;
   logic [31:0] rem;

   assign abs1 = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

   // Bit 64 is always clear between steps, so rotating it into bit 0 is a plain shift.
   assign shifted = {dividend[63:0], dividend[64]};
   assign trial   = {1'b0, shifted[64:32]} - {2'b00, divisor};

   assign quot = neg_quot ? -dividend[31:0]  : dividend[31:0];
   assign rem  = neg_rem  ? -dividend[63:32] : dividend[63:32];

   assign stall_req_o = start_i & ~ready_o;

   always_ff @(posedge clk) begin
      if (Rst_n) begin
         state    <= FREE;
         cnt      <= 6'd0;
         dividend <= 65'd0;
         divisor  <= 32'd0;
         neg_quot <= 1'b0;
         neg_rem  <= 1'b0;
         result_o <= 64'd0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     state <= BYZERO;
                  end else begin
                     state    <= ON;
                     cnt      <= 6'd0;
                     dividend <= {33'd0, abs1};
                     divisor  <= abs2;
                     neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     neg_rem  <= signed_div_i & opdata1_i[31];
                  end
               end
            end
            BYZERO: begin
               result_o <= 64'd0;
               ready_o  <= 1'b1;
               state    <= END;
            end
            ON: begin
               if (annul_i) begin
                  state <= FREE;
               end else if (cnt != 6'd32) begin
                  // A non-negative trial leaves a difference below the divisor, so trial[32] is 0.
                  if (!trial[33])
                     dividend <= {trial[32:0], shifted[31:1], 1'b1};
                  else
                     dividend <= shifted;
                  cnt <= cnt + 6'd1;
               end else begin
                  result_o <= {rem, quot};
                  ready_o  <= 1'b1;
                  state    <= END;
               end
            end
            END: begin
               if (!start_i) begin
                  state    <= FREE;
                  ready_o  <= 1'b0;
                  result_o <= 64'd0;
               end
            end
            default: state <= FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed table-driven bench for div_ctrl
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        Rst_n;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stall_req_o;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[12];

   div_ctrl dut (
      .clk(clk),
      .Rst_n(Rst_n),
      .signed_div_i(signed_div_i),
      .opdata1_i(opdata1_i),
      .opdata2_i(opdata2_i),
      .start_i(start_i),
      .annul_i(annul_i),
      .result_o(result_o),
      .ready_o(ready_o),
      .stall_req_o(stall_req_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   task automatic watch_idle(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (ready_o || result_o != 64'd0) seen = 1'b1;
      end
      check(name, {63'd0, seen}, 64'd0);
   endtask

   task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      int   edges;
      logic got;
      logic stall_ok;
      @(negedge clk);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      edges        = 0;
      got          = 1'b0;
      stall_ok     = 1'b1;
      while (!got && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) begin
            // Operands change while busy; only the latched values may matter.
            signed_div_i = ~sgn;
            opdata1_i    = ~a;
            opdata2_i    = ~b;
         end
         if (ready_o) got = 1'b1;
         else if (!stall_req_o) stall_ok = 1'b0;
      end
      check({name, " latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
      check({name, " stall_before_ready"}, {63'd0, stall_ok}, 64'd1);
      check({name, " result"}, result_o, exp);
      check({name, " stall_at_ready"}, {63'd0, stall_req_o}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      check({name, " hold_ready"}, {63'd0, ready_o}, 64'd1);
      check({name, " hold_result"}, result_o, exp);
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, " release"}, {ready_o, result_o[62:0]} | {63'd0, result_o[63]}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD};
      vecs[2]  = '{1'b0, 32'h12345678,   32'h00000000,   64'h00000000_00000000};
      vecs[3]  = '{1'b1, 32'h87654321,   32'h00000000,   64'h00000000_00000000};
      vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001};
      vecs[6]  = '{1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF,   64'hFFFFFFFE_00000000};
      vecs[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
      vecs[8]  = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   64'hFFFFFFFE_00000002};
      vecs[9]  = '{1'b0, 32'h80000000,   32'd3,          64'h00000002_2AAAAAAA};
      vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   64'h7FFFFFFF_00000001};
      vecs[11] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC};

      Rst_n = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
      start_i = 1'b0; annul_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready", {63'd0, ready_o}, 64'd0);
      check("reset result", result_o, 64'd0);
      check("reset stall", {63'd0, stall_req_o}, 64'd0);
      Rst_n = 1'b0;

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Annul at edge 10 of an operation.
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      check("annul ready", {63'd0, ready_o}, 64'd0);
      watch_idle("annul no_ready");
      run_op("after_annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);

      // Reset at edge 20 of an operation.
      @(negedge clk);
      signed_div_i = 1'b1; opdata1_i = 32'hFFFFFF00; opdata2_i = 32'd5; start_i = 1'b1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      Rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midreset ready", {63'd0, ready_o}, 64'd0);
      check("midreset result", result_o, 64'd0);
      Rst_n = 1'b0; start_i = 1'b0;
      watch_idle("midreset no_stale");
      run_op("after_reset", 1'b1, 32'hFFFFFF00, 32'd5, 64'hFFFFFFFF_FFFFFFCD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
